// File: rtl/axi_rd_arbiter_pkg.sv
// Purpose: shared IDs, AR encodings, FSM state type and AR request record for the read arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: INST_ID/DATA_ID, BURST_LEN/BEAT_SIZE_W, counter width,
// arb_state_e {IDLE, ADDR}, ar_req_t and the build_ar() helper.
package axi_rd_arbiter_pkg;

  localparam logic [3:0] INST_ID     = 4'h0;
  localparam logic [3:0] DATA_ID     = 4'h1;
  localparam logic [7:0] BURST_LEN   = 8'h3;   // 4-beat cache-line refill
  localparam logic [2:0] BEAT_SIZE_W = 3'h2;   // 4-byte beats

  // Wide enough for the largest legal MAX_OUTS (7).
  localparam int CNT_W = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ADDR = 1'b1
  } arb_state_e;

  // Everything the AR channel presents for one transaction.
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_req_t;

  // Instruction reads are always word sized; only a refill is a burst.
  // Data reads are single beats of the requested size.
  function automatic ar_req_t build_ar(input logic [3:0]  id,
                                       input logic [31:0] addr,
                                       input logic        burst,
                                       input logic [2:0]  size);
    ar_req_t r;
    r.id   = id;
    r.addr = addr;
    if (id == INST_ID) begin
      r.len  = burst ? BURST_LEN : 8'h0;
      r.size = BEAT_SIZE_W;
    end else begin
      r.len  = 8'h0;
      r.size = size;
    end
    return r;
  endfunction

endpackage

// File: rtl/rd_outs_cnt.sv
// Purpose: per-ID outstanding-read counter, saturating in both directions, with full flag.
// Latency: count updates one cycle after inc/dec; full/busy are combinational from the count.
// Backpressure: none; the caller stops issuing while full is high.
//
// Ports: aclk, areset (async, active high), inc (AR accepted), dec (last R beat),
//        full (count >= MAX_OUTS), busy (count != 0).
module rd_outs_cnt
  import axi_rd_arbiter_pkg::*;
#(
  parameter int MAX_OUTS = 2
) (
  input  logic aclk,
  input  logic areset,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic busy
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTS);

  logic [CNT_W-1:0] cnt;

  // inc together with dec cancels out. A stray dec at zero (e.g. an R beat
  // that belonged to a transaction wiped by reset) is ignored.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      if (!full) begin
        cnt <= cnt + 1'b1;
      end
    end else if (dec && !inc) begin
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign full = (cnt >= MAX_CNT);
  assign busy = (cnt != '0);

endmodule

// File: rtl/axi_rd_arbiter.sv
// Purpose: arbitrates inst/data read requests onto one AXI AR channel and routes R beats back by ID.
// Latency: req -> arvalid 1 cycle (registered); addr_ok/data_ok/rdata/rlast combinational.
// Backpressure: holds arvalid until arready; no new AR while wr_pending or the ID is at MAX_OUTS; rready tied high.
//
// Ports: aclk, areset (async, active high);
//        inst_req/inst_burst/inst_addr, data_req/data_addr/data_size -> requester side;
//        inst_addr_ok/data_addr_ok, inst_data_ok/data_data_ok, inst_rdata/data_rdata, inst_rlast;
//        wr_pending (from write path), rd_busy (to write path);
//        arid/araddr/arlen/arsize/arvalid/arready, rid/rdata/rlast/rvalid/rready -> AXI.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is
//               fixed priority with data ahead of instruction.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int MAX_OUTS = 2
) (
  input  logic        aclk,
  input  logic        areset,
  // requester side
  input  logic        inst_req,
  input  logic        inst_burst,
  input  logic [31:0] inst_addr,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [2:0]  data_size,
  output logic        inst_addr_ok,
  output logic        data_addr_ok,
  output logic        inst_data_ok,
  output logic        data_data_ok,
  output logic [31:0] inst_rdata,
  output logic [31:0] data_rdata,
  output logic        inst_rlast,
  // ordering against the write path
  input  logic        wr_pending,
  output logic        rd_busy,
  // AXI AR
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  // AXI R
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  arb_state_e state_q;
  ar_req_t    ar_q;

  logic inst_full, data_full;
  logic inst_busy, data_busy;
  logic inst_elig, data_elig;
  logic grant_data;
  logic ar_start;
  logic ar_hs;
  logic r_inst, r_data;

  // ---------------------------------------------------------------------------
  // Eligibility and arbitration
  // ---------------------------------------------------------------------------
  assign inst_elig = inst_req && !inst_full;
  assign data_elig = data_req && !data_full;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers who won the last accepted AR; reset value means "inst", so
  // the first contended grant goes to data.
  logic last_data_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      last_data_q <= 1'b0;
    end else if (ar_hs) begin
      last_data_q <= (ar_q.id == DATA_ID);
    end
  end

  always_comb begin
    grant_data = data_elig;
    if (inst_elig && data_elig) begin
      grant_data = !last_data_q;
    end
  end
`else
  assign grant_data = data_elig;
`endif

  // A new read may only start from IDLE, and never while a store is in
  // flight, so it cannot overtake that store.
  assign ar_start = (state_q == IDLE) && (inst_elig || data_elig) && !wr_pending;
  assign ar_hs    = (state_q == ADDR) && arready;

  // ---------------------------------------------------------------------------
  // AR state and registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      ar_q    <= '0;
    end else if (state_q == IDLE) begin
      if (ar_start) begin
        state_q <= ADDR;
        ar_q    <= grant_data ? build_ar(DATA_ID, data_addr, 1'b0, data_size)
                              : build_ar(INST_ID, inst_addr, inst_burst, 3'h0);
      end
    end else begin
      // Once presented, the AR completes regardless of wr_pending.
      if (arready) begin
        state_q <= IDLE;
      end
    end
  end

  assign arvalid = (state_q == ADDR);
  assign arid    = ar_q.id;
  assign araddr  = ar_q.addr;
  assign arlen   = ar_q.len;
  assign arsize  = ar_q.size;

  assign inst_addr_ok = ar_hs && (ar_q.id == INST_ID);
  assign data_addr_ok = ar_hs && (ar_q.id == DATA_ID);

  // ---------------------------------------------------------------------------
  // R routing; beats with an unknown ID are accepted and dropped
  // ---------------------------------------------------------------------------
  assign rready = 1'b1;

  assign r_inst = rvalid && (rid == INST_ID);
  assign r_data = rvalid && (rid == DATA_ID);

  assign inst_data_ok = r_inst;
  assign inst_rdata   = r_inst ? rdata : 32'h0;
  assign inst_rlast   = r_inst && rlast;

  assign data_data_ok = r_data;
  assign data_rdata   = r_data ? rdata : 32'h0;

  // ---------------------------------------------------------------------------
  // Outstanding tracking per ID
  // ---------------------------------------------------------------------------
  rd_outs_cnt #(
    .MAX_OUTS (MAX_OUTS)
  ) u_inst_cnt (
    .aclk   (aclk),
    .areset (areset),
    .inc    (inst_addr_ok),
    .dec    (r_inst && rlast),
    .full   (inst_full),
    .busy   (inst_busy)
  );

  rd_outs_cnt #(
    .MAX_OUTS (MAX_OUTS)
  ) u_data_cnt (
    .aclk   (aclk),
    .areset (areset),
    .inc    (data_addr_ok),
    .dec    (r_data && rlast),
    .full   (data_full),
    .busy   (data_busy)
  );

  assign rd_busy = inst_busy || data_busy;

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Read-address arbiter and response router between the CPU-side request ports (instruction cache and data path) and the single AXI read channel pair (AR/R). It picks one requester per AR transaction, drives ARID, ARLEN and ARSIZE, and tracks outstanding reads per ID. It holds off new reads while a write is pending on the write path, so a read never overtakes a store. The bridge top instantiates it in place of inline AR logic; the AW/W/B path stays outside this block.

## Interface
- MAX_OUTS, 2: maximum outstanding AR transactions per ID (1..7).
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- inst_req / data_req  in  1  read request from instruction / data requester, held until addr_ok.
- inst_burst  in  1  instruction request is a 4-beat cache-line refill.
- inst_addr / data_addr  in  32  read address.
- data_size  in  3  data read size (0: 1 B, 1: 2 B, 2: 4 B).
- inst_addr_ok / data_addr_ok  out  1  AR handshake completed for this requester.
- inst_data_ok / data_data_ok  out  1  R beat for this requester.
- inst_rdata / data_rdata  out  32  R data, zero when the beat is not for this requester.
- inst_rlast  out  1  last beat of an instruction read.
- wr_pending  in  1  write path has an issued write without a B response.
- arid  out  4  value is 0 for instruction reads, 1 for data reads.
- araddr  out  32  read address.
- arlen  out  8  burst length.
- arsize  out  3  beat size.
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rid  in  4  R ID.
- rdata  in  32  R data.
- rlast  in  1  R last beat.
- rvalid  in  1  R valid.
- rready  out  1  R ready.
- rd_busy  out  1  any outstanding read exists; the write path uses it for the reverse ordering check.

## Operation
- FSM has two states. IDLE: AR register empty. ADDR: arvalid=1, waiting for arready.
- IDLE → ADDR when a requester is eligible and wr_pending=0. Capture id, addr, len and size into the AR registers.
- Eligibility: req=1 and that ID's outstanding count < MAX_OUTS.
- ADDR → IDLE on arvalid&&arready:
  - pulse the owner's addr_ok for that same cycle;
  - increment the owner's outstanding counter.
- Instruction burst: arlen=3, arsize=2. Instruction non-burst: arlen=0, arsize=2. Data read: arlen=0, arsize=data_size.
- rready is constant 1.
- R routing:
  - rid==0 drives inst_data_ok=rvalid, inst_rdata=rdata and inst_rlast=rvalid&&rlast.
  - rid==1 drives the data_* outputs the same way.
  - Any other rid is dropped with no ok pulse.
- Counter decrement: on rvalid&&rlast, decrement the counter of the matching ID.
- Increment and decrement of the same ID in one cycle leave the counter unchanged.
- A decrement at 0 saturates at 0 and never underflows.
- rd_busy = OR of the counters being non-zero.
- wr_pending only gates the IDLE→ADDR transition. A transaction already in ADDR completes regardless.
- Arbitration policy is set by the configuration macro described below.

## Timing
- Reset values:
  - arvalid=0, arid=0, araddr=0, arlen=0, arsize=0;
  - both counters 0; FSM=IDLE; round-robin pointer = inst.
  - rready=1 in and out of reset.
- Reset asserted mid-transaction drops arvalid immediately and clears both counters. R beats arriving afterwards are still routed, and their counter decrement saturates at 0.
- Request to arvalid: 1 cycle (registered).
- Minimum AR-to-AR spacing is 2 cycles, because IDLE is visited between transactions.
- addr_ok is combinational from arready in ADDR. data_ok, rdata and rlast are combinational from R.
- A requester must hold req, addr, size and burst stable until its addr_ok.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - when both requesters are eligible, grant the one not granted last;
  - the pointer updates on each AR handshake.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, data over instruction. No pointer register exists.

## Structure
- Shared package holds:
  - INST_ID=4'h0 and DATA_ID=4'h1;
  - the burst encodings BURST_LEN=8'h3 and BEAT_SIZE_W=3'h2;
  - an FSM state enum {IDLE, ADDR}.
- One sub-module, rd_outs_cnt: a per-ID saturating up/down counter with a full flag. The block instantiates it twice.

## Test plan
- Single data read: data_req, addr 0x1c000010, size 2, arready=1 → arvalid in cycle 1, arid=1, arlen=0, data_addr_ok in cycle 1; an R beat with rid=1 and data 0xdeadbeef gives data_data_ok with that data.
- Instruction burst: inst_req with inst_burst, addr 0x1c008000 → arlen=3, arsize=2; four R beats with rid=0 give 4 inst_data_ok pulses, inst_rlast only on the 4th, and the counter returns to 0.
- Contention: both requesters request continuously.
  - With the macro undefined, data wins every grant until it reaches MAX_OUTS=2.
  - With the macro defined, grants alternate data, inst, data, inst.
- Write hazard: wr_pending=1 for 5 cycles with data_req high → no arvalid during those cycles; arvalid rises 1 cycle after wr_pending falls.
- Outstanding limit: issue 2 data reads with no R response → the 3rd request stalls; a single rlast beat with rid=1 → the 3rd issues next IDLE cycle; a simultaneous grant and rlast leaves the count at 2.
- Reset with arvalid=1 and count=1 → arvalid=0 asynchronously and rd_busy=0; a stray rlast with rid=1 afterwards keeps the count at 0.
